// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the program-run sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SEL     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    localparam int HALT_PC_P1 = 71;
    localparam int HALT_PC_P2 = 90;
    localparam int HALT_PC_P3 = 139;

endpackage

// File: rtl/run_ctrl_halt_pc_lut.sv
// Program select to halt-PC lookup; select 3 is rejected upstream, so its value is a don't-care.
module halt_pc_lut
    import run_ctrl_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic [1:0]      prog_sel,
    output logic [PC_W-1:0] halt_pc
);

    always_comb begin
        halt_pc = '0;
        case (prog_sel)
            2'd0:    halt_pc = PC_W'(HALT_PC_P1);
            2'd1:    halt_pc = PC_W'(HALT_PC_P2);
            2'd2:    halt_pc = PC_W'(HALT_PC_P3);
            default: halt_pc = '0;
        endcase
    end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in init, releases it, watches for the halt PC or a timeout,
// and parks the core in init until the host acknowledges.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int CNT_W       = 16,
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [1:0]       prog_sel,
    input  logic             abort,
    input  logic             ack,
    input  logic [PC_W-1:0]  pc,
    output logic             core_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_t          state, state_nx;
    logic [IW-1:0]   init_cnt;
    logic [PC_W-1:0] halt_pc, lut_pc;
    logic            sel_ok, halt_hit, timeout_hit;

    halt_pc_lut #(.PC_W(PC_W)) u_lut (
        .prog_sel (prog_sel),
        .halt_pc  (lut_pc)
    );

    assign sel_ok      = (prog_sel != 2'd3);
    assign halt_hit    = (pc == halt_pc);
    // Compare against the pre-increment count so the timeout cycle itself is counted.
    assign timeout_hit = (cycle_count == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (go) state_nx = sel_ok ? INIT : ERR;
            INIT: begin
                if (abort)              state_nx = IDLE;
                else if (init_cnt == '0) state_nx = RUN;
            end
            RUN: begin
                if (abort)            state_nx = IDLE;
                else if (halt_hit)    state_nx = DONE;
                else if (timeout_hit) state_nx = ERR;
            end
            DONE, ERR: if (ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            core_start  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
            halt_pc     <= '0;
            init_cnt    <= '0;
        end else begin
            state      <= state_nx;
            core_start <= (state_nx != RUN);
            busy       <= (state_nx == INIT) || (state_nx == RUN);
            done       <= (state_nx == DONE);
            err        <= (state_nx == ERR);
            case (state)
                IDLE: begin
                    if (go && sel_ok) begin
                        halt_pc     <= lut_pc;
                        cycle_count <= '0;
                        err_code    <= ERR_NONE;
                        init_cnt    <= IW'(INIT_CYCLES - 1);
                    end else if (go) begin
                        err_code    <= ERR_SEL;
                    end
                end
                INIT: if (init_cnt != '0) init_cnt <= init_cnt - 1'b1;
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    if (state_nx == ERR) err_code <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (short and default timeout) share the host controls and
// are each checked every cycle against a plain-arithmetic reference model.
module tb_run_ctrl;

    localparam int PC_W        = 12;
    localparam int CNT_W       = 16;
    localparam int INIT_CYCLES = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             go = 1'b0, abort = 1'b0, ack = 1'b0;
    logic [1:0]       prog_sel = 2'd0;
    logic [PC_W-1:0]  pc_v [2];
    logic             cs [2], bsy [2], dn [2], er [2];
    logic [1:0]       ec [2];
    logic [CNT_W-1:0] cc [2];

    int n_chk = 0;
    int n_fail = 0;

    run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .INIT_CYCLES(INIT_CYCLES), .TIMEOUT(16)) u_a (
        .clk(clk), .reset_n(reset_n), .go(go), .prog_sel(prog_sel), .abort(abort), .ack(ack),
        .pc(pc_v[0]), .core_start(cs[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]),
        .err_code(ec[0]), .cycle_count(cc[0])
    );

    run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .INIT_CYCLES(INIT_CYCLES), .TIMEOUT(4096)) u_b (
        .clk(clk), .reset_n(reset_n), .go(go), .prog_sel(prog_sel), .abort(abort), .ack(ack),
        .pc(pc_v[1]), .core_start(cs[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]),
        .err_code(ec[1]), .cycle_count(cc[1])
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 init, 2 run, 3 done, 4 err.
    int m_mode [2];
    int m_cnt  [2];
    int m_ec   [2];
    int m_halt [2];
    int m_left [2];
    int tmo    [2] = '{16, 4096};
    int halts  [3] = '{71, 90, 139};
    int force_cnt [2] = '{-1, -1};
    bit pc_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_ec[i] = 0; m_halt[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic mstep(input int i, input bit g, input int s, input bit ab, input bit ak, input int p);
        case (m_mode[i])
            0: if (g) begin
                if (s < 3) begin
                    m_halt[i] = halts[s]; m_cnt[i] = 0; m_ec[i] = 0;
                    m_left[i] = INIT_CYCLES; m_mode[i] = 1;
                end else begin
                    m_mode[i] = 4; m_ec[i] = 1;
                end
            end
            1: if (ab) m_mode[i] = 0;
               else begin
                   m_left[i]--;
                   if (m_left[i] == 0) m_mode[i] = 2;
               end
            2: begin
                m_cnt[i]++;
                if (ab)                   m_mode[i] = 0;
                else if (p == m_halt[i])  m_mode[i] = 3;
                else if (m_cnt[i] == tmo[i]) begin m_mode[i] = 4; m_ec[i] = 2; end
            end
            default: if (ak) m_mode[i] = 0;
        endcase
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("core_start[%0d]", i), 32'(cs[i]), 32'(m_mode[i] != 2));
            chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_mode[i] == 1 || m_mode[i] == 2));
            chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_mode[i] == 3));
            chk($sformatf("err[%0d]", i), 32'(er[i]), 32'(m_mode[i] == 4));
            chk($sformatf("err_code[%0d]", i), 32'(ec[i]), 32'(m_ec[i]));
            chk($sformatf("cycle_count[%0d]", i), 32'(cc[i]), 32'(m_cnt[i]));
        end
    endtask

    // Stub core PC: counts from 0 in RUN, with an optional forced halt or random values.
    function automatic logic [PC_W-1:0] pc_val(input int i);
        if (m_mode[i] != 2)          return PC_W'($urandom_range(0, 4095));
        if (m_cnt[i] == force_cnt[i]) return PC_W'(m_halt[i]);
        if (pc_rand)
            return ($urandom_range(0, 19) == 0) ? PC_W'(m_halt[i]) : PC_W'($urandom_range(0, 4095));
        return PC_W'(m_cnt[i]);
    endfunction

    task automatic cyc(input bit g, input int s, input bit ab, input bit ak);
        go = g; prog_sel = s[1:0]; abort = ab; ack = ak;
        pc_v[0] = pc_val(0); pc_v[1] = pc_val(1);
        @(posedge clk);
        mstep(0, g, s, ab, ak, int'(pc_v[0]));
        mstep(1, g, s, ab, ak, int'(pc_v[1]));
        #1 check_all();
    endtask

    task automatic run_idle(input int n);
        repeat (n) cyc(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Reset dropped between edges: outputs must go to reset values before any clock edge.
    task automatic do_areset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 mreset();
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        pc_v[0] = '0; pc_v[1] = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1 check_all();
        chk("rst_core_start", 32'(cs[0]), 32'd1);
        reset_n = 1'b1;

        // prog 0 with counting PC: long instance completes at 72, short one times out at 16
        cyc(1'b1, 0, 1'b0, 1'b0);
        run_idle(80);
        chk("p0_done_b", 32'(dn[1]), 32'd1);
        chk("p0_count_b", 32'(cc[1]), 32'd72);
        chk("p0_busy_b", 32'(bsy[1]), 32'd0);
        chk("tmo_code_a", 32'(ec[0]), 32'd2);
        chk("tmo_count_a", 32'(cc[0]), 32'd16);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("ack_err_a", 32'(er[0]), 32'd0);

        // invalid select
        cyc(1'b1, 3, 1'b0, 1'b0);
        chk("badsel_err", 32'(er[0]), 32'd1);
        chk("badsel_code", 32'(ec[1]), 32'd1);
        chk("badsel_cs", 32'(cs[1]), 32'd1);
        chk("badsel_cnt", 32'(cc[1]), 32'd72);
        cyc(1'b0, 0, 1'b1, 1'b1);
        chk("badsel_ack", 32'(er[1]), 32'd0);

        // halt on the timeout cycle: done wins
        force_cnt[0] = 15;
        cyc(1'b1, 1, 1'b0, 1'b0);
        run_idle(20);
        chk("halt_on_tmo_done", 32'(dn[0]), 32'd1);
        chk("halt_on_tmo_err", 32'(er[0]), 32'd0);
        chk("halt_on_tmo_cnt", 32'(cc[0]), 32'd16);
        force_cnt[0] = -1;
        cyc(1'b0, 0, 1'b1, 1'b1);

        // abort on RUN cycle 10, with go pulses ignored while running
        cyc(1'b1, 2, 1'b0, 1'b0);
        run_idle(2);
        for (int k = 0; k < 9; k++) cyc(k[0], $urandom_range(0, 3), 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0);
        chk("abort_cnt_a", 32'(cc[0]), 32'd10);
        chk("abort_cnt_b", 32'(cc[1]), 32'd10);
        chk("abort_cs", 32'(cs[1]), 32'd1);
        chk("abort_done", 32'(dn[1]), 32'd0);

        // async reset mid-run, then prog 2 to completion
        cyc(1'b1, 2, 1'b0, 1'b0);
        run_idle(30);
        do_areset();
        chk("areset_cs", 32'(cs[1]), 32'd1);
        chk("areset_cnt", 32'(cc[1]), 32'd0);
        cyc(1'b1, 2, 1'b0, 1'b0);
        run_idle(150);
        chk("p2_done", 32'(dn[1]), 32'd1);
        chk("p2_count", 32'(cc[1]), 32'd140);

        // back-to-back: prog 1, ack, prog 2 right away
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1, 1'b0, 1'b0);
        run_idle(100);
        chk("p1_count", 32'(cc[1]), 32'd91);
        cyc(1'b0, 0, 1'b0, 1'b1);
        cyc(1'b1, 2, 1'b0, 1'b0);
        chk("b2b_clear", 32'(cc[1]), 32'd0);
        run_idle(145);
        chk("b2b_count", 32'(cc[1]), 32'd140);

        // random host traffic
        pc_rand = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_areset();
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3),
                $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Program-run sequencer for the 9-bit-instruction processor core.
- Takes a host "go" with a program select and drives the core's start/init line through an init window, then lets the core run.
- Detects the program-specific halt PC, replacing the hardcoded per-program done compare, and counts execution cycles.
- Flags a timeout or bad select, then parks the core until the host acknowledges.
- Sits between the testbench/host and the core top level. The core consumes `core_start`; `pc` is fed back from the core's fetch unit.

Parameters:
- PC_W, 12, width of core program counter
- CNT_W, 16, width of cycle counter
- INIT_CYCLES, 2, cycles core_start is held high before release (>=1)
- TIMEOUT, 4096, RUN cycles allowed before error (<= 2^CNT_W - 1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- go  in  1  start request, sampled in IDLE only
- prog_sel  in  2  program select: 0,1,2 valid; 3 invalid
- abort  in  1  cancel an INIT/RUN in progress
- ack  in  1  acknowledge DONE/ERR, return to IDLE
- pc  in  PC_W  current core PC
- core_start  out  1  to core init/start input; high holds the core in init
- busy  out  1  high in INIT or RUN
- done  out  1  high in DONE
- err  out  1  high in ERR
- err_code  out  2  0 none, 1 bad select, 2 timeout
- cycle_count  out  CNT_W  RUN cycles of last/current run

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- All outputs registered. Reset values: state IDLE, core_start=1, busy=0, done=0, err=0, err_code=0, cycle_count=0, halt_pc=0, init counter=0.
- States: IDLE, INIT, RUN, DONE, ERR. core_start=1 in IDLE, INIT, DONE, ERR; 0 only in RUN. A finished core is thus frozen in init.
- IDLE:
  - go=1 with prog_sel<3: latch halt_pc from LUT (0->71, 1->90, 2->139), clear cycle_count and err_code, load init counter = INIT_CYCLES-1, enter INIT next cycle.
  - go=1 with prog_sel=3: enter ERR with err_code=1; cycle_count untouched.
  - abort and ack are ignored in IDLE.
- INIT:
  - Decrement counter each cycle; on counter=0, enter RUN.
  - core_start is high for exactly INIT_CYCLES cycles, then RUN begins.
- RUN:
  - cycle_count increments every RUN cycle, including the cycle in which pc==halt_pc.
  - pc==halt_pc: enter DONE next cycle.
  - Else if cycle_count==TIMEOUT-1 (pre-increment): enter ERR, err_code=2, cycle_count=TIMEOUT.
- DONE/ERR:
  - cycle_count and err_code hold.
  - ack=1: enter IDLE next cycle. done/err clear on that transition; cycle_count keeps its value until the next valid go.
- go is ignored outside IDLE. prog_sel is only sampled with go.
- abort in INIT or RUN: IDLE next cycle, no done/err, cycle_count holds partial value. abort in DONE/ERR is ignored.
- Priority in RUN (highest first): abort > halt match > timeout. A halt on the timeout cycle gives DONE.
- reset_n asserted mid-run: immediate return to reset values; core_start goes high asynchronously.
- No wrap: cycle_count never exceeds TIMEOUT.

Decomposition:
- Package run_ctrl_pkg:
  - state enum state_t {IDLE, INIT, RUN, DONE, ERR}
  - err_code enum {ERR_NONE=0, ERR_SEL=1, ERR_TIMEOUT=2}
  - halt PC constants HALT_PC_P1=71, HALT_PC_P2=90, HALT_PC_P3=139
- Sub-module halt_pc_lut: combinational prog_sel -> halt PC. Returns 0 for sel 3; that value is never used.

Test Plan:
- Reset then go, prog_sel=0, INIT_CYCLES=2, stub pc counting 0,1,2… from the first RUN cycle -> core_start high 2 cycles after go, pc=71 on RUN cycle 72, done=1 next cycle, cycle_count=72, busy=0.
- go with prog_sel=3 -> err=1, err_code=1 one cycle later, core_start stays 1. ack -> IDLE, err=0.
- TIMEOUT=16, pc never matches -> err_code=2 after 16 RUN cycles, cycle_count=16. Second variant with halt on cycle 16 -> done wins, err=0.
- abort on RUN cycle 10 -> IDLE next cycle, done=0, err=0, cycle_count=10, core_start=1. go pulses during RUN are ignored.
- reset_n low mid-RUN for 1 cycle (async, between edges) -> core_start=1 and all outputs at reset values immediately. A new go with prog_sel=2 then completes at pc=139, cycle_count=140.
- Back-to-back: prog 1 done -> ack -> go prog 2 in the cycle after IDLE is reached -> halt_pc=139 latched, cycle_count restarts from 0.
